// File: rtl/cs_stream_driver_if.sv
// rtl/cs_stream_driver_if.sv - signal bundle between cs_stream_driver, its sample source, the CS averager and the result sink
//   in_valid/in_ready/in_data : upstream 8-bit sample handshake
//   start/stop                : stream control (start honoured in IDLE, stop in STREAM)
//   cs_reset/cs_x/cs_y        : CS averager reset, sample input, 10-bit combinational result
//   out_valid/out_data/out_index : single-cycle result strobe, captured CS result, window number
//   busy/underrun             : PRIME-or-STREAM flag, sticky FIFO-ran-dry flag
//   slave  : the driver side
//   master : the surrounding system side
interface cs_stream_driver_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        start;
    logic        stop;
    logic        cs_reset;
    logic [7:0]  cs_x;
    logic [9:0]  cs_y;
    logic        out_valid;
    logic [9:0]  out_data;
    logic [15:0] out_index;
    logic        busy;
    logic        underrun;

    modport slave (
        input  in_valid, in_data, start, stop, cs_y,
        output in_ready, cs_reset, cs_x, out_valid, out_data, out_index, busy, underrun
    );

    modport master (
        output in_valid, in_data, start, stop, cs_y,
        input  in_ready, cs_reset, cs_x, out_valid, out_data, out_index, busy, underrun
    );
endinterface

// File: rtl/cs_stream_driver.sv
// rtl/cs_stream_driver.sv - FIFO-buffered sample feeder and result capture for the CS 9-sample averager
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : cs_stream_driver_if.slave (upstream samples, start/stop, CS drive/result, result strobe, status)
module cs_stream_driver #(
    parameter int DEPTH       = 16,
    parameter int START_LEVEL = 9,
    parameter int WIN         = 9
) (
    input  logic              clk,
    input  logic              reset,
    cs_stream_driver_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_pop_cnt;
    logic          r_underrun;
    logic          r_out_valid;
    logic [9:0]    r_out_data;
    logic [15:0]   r_out_index;

    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_begin;
    logic          w_set_underrun;
    logic          w_cs_reset;
    logic [7:0]    w_cs_x;

    // Full is judged from the registered count only, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign w_in_ready = (r_count < CW'(DEPTH));
    assign w_push     = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_pop          = 1'b0;
        w_begin        = 1'b0;
        w_set_underrun = 1'b0;
        w_cs_reset     = 1'b1;
        w_cs_x         = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_PRIME;
                    w_begin      = 1'b1;
                end
            end
            S_PRIME: begin
                if (r_count >= CW'(START_LEVEL)) begin
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                // CS has no stall input: an empty FIFO ends the stream.
                w_cs_reset = 1'b0;
                if (r_count == '0) begin
                    w_set_underrun = 1'b1;
                    w_next_state   = S_IDLE;
                end else begin
                    w_pop  = 1'b1;
                    w_cs_x = r_mem[r_rd_ptr];
                    if (bus.stop) begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The pop counter lags the pops by one cycle; once it reaches WIN the
    // CS output covers WIN real samples, the oldest being window number
    // r_pop_cnt - WIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pop_cnt   <= '0;
            r_underrun  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
        end else begin
            if (w_begin) begin
                r_pop_cnt <= '0;
            end else if (w_pop && (r_pop_cnt != 16'hFFFF)) begin
                r_pop_cnt <= r_pop_cnt + 16'd1;
            end

            if (w_begin) begin
                r_underrun <= 1'b0;
            end else if (w_set_underrun) begin
                r_underrun <= 1'b1;
            end

            if ((r_state == S_STREAM) && (r_pop_cnt >= 16'(WIN))) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.cs_y;
                r_out_index <= r_pop_cnt - 16'(WIN);
            end else begin
                r_out_valid <= 1'b0;
                if (w_begin) begin
                    r_out_index <= '0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.cs_reset  = w_cs_reset;
    assign bus.cs_x      = w_cs_x;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_index = r_out_index;
    assign bus.busy      = (r_state == S_PRIME) || (r_state == S_STREAM);
    assign bus.underrun  = r_underrun;
endmodule

// File: tb/tb_cs_stream_driver.sv
// tb/tb_cs_stream_driver.sv - directed self-checking bench for cs_stream_driver with a CS averager model
module tb_cs_stream_driver;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cs_stream_driver_if bus_if ();

    cs_stream_driver #(
        .DEPTH      (16),
        .START_LEVEL(9),
        .WIN        (9)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    // CS averager: 9-sample shift window, Y = (Sum + 9*X_Appr) >> 3,
    // X_Appr = largest sample not above floor(Sum/9).
    logic [7:0]  cs_win [9];
    logic [11:0] cs_sum;
    logic [7:0]  cs_avg;
    logic [7:0]  cs_appr;
    logic [12:0] cs_tot;

    always @(posedge clk) begin
        if (bus_if.cs_reset) begin
            for (int i = 0; i < 9; i++) cs_win[i] <= '0;
        end else begin
            cs_win[0] <= bus_if.cs_x;
            for (int i = 1; i < 9; i++) cs_win[i] <= cs_win[i-1];
        end
    end

    always_comb begin
        cs_sum = '0;
        for (int i = 0; i < 9; i++) cs_sum = cs_sum + 12'(cs_win[i]);
        cs_avg  = 8'(cs_sum / 12'd9);
        cs_appr = '0;
        for (int i = 0; i < 9; i++) begin
            if ((cs_win[i] <= cs_avg) && (cs_win[i] > cs_appr)) cs_appr = cs_win[i];
        end
        cs_tot      = 13'(cs_sum) + 13'(cs_appr) * 13'd9;
        bus_if.cs_y = 10'(cs_tot >> 3);
    end

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        bus_if.start    = 1'b0;
        bus_if.stop     = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic push_n(input int base, input int incr, input int n);
        for (int i = 0; i < n; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = 8'(base + i * incr);
            step();
        end
        bus_if.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while ((bus_if.out_valid !== 1'b1) && (k < 40)) begin
            step();
            k++;
        end
    endtask

    task automatic fill_count(output int n);
        n = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'd77;
        while ((bus_if.in_ready === 1'b1) && (n < 20)) begin
            step();
            n++;
        end
        bus_if.in_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        int exp5 [4];
        exp5 = '{11, 13, 15, 18};

        // reset values, sampled while reset is held
        reset           = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        bus_if.start    = 1'b0;
        bus_if.stop     = 1'b0;
        step();
        step();
        check("rst_in_ready",  bus_if.in_ready,  1);
        check("rst_cs_reset",  bus_if.cs_reset,  1);
        check("rst_cs_x",      bus_if.cs_x,      0);
        check("rst_busy",      bus_if.busy,      0);
        check("rst_out_valid", bus_if.out_valid, 0);
        check("rst_underrun",  bus_if.underrun,  0);
        check("rst_out_index", bus_if.out_index, 0);
        check("rst_out_data",  bus_if.out_data,  0);
        reset = 1'b0;

        // steady stream of 10s with continuous refill
        push_n(10, 0, 9);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'd10;
        pulse_start();
        check("t2_busy_prime", bus_if.busy, 1);
        check("t2_csrst_prime", bus_if.cs_reset, 1);
        wait_valid(k);
        check("t2_latency", k, 11);
        check("t2_data0",   bus_if.out_data,  22);
        check("t2_index0",  bus_if.out_index, 0);
        for (int j = 1; j <= 5; j++) begin
            step();
            check("t2_valid", bus_if.out_valid, 1);
            check("t2_data",  bus_if.out_data,  22);
            check("t2_index", bus_if.out_index, j);
        end
        check("t2_no_underrun", bus_if.underrun, 0);
        bus_if.in_valid = 1'b0;
        bus_if.stop     = 1'b1;
        step();
        bus_if.stop = 1'b0;
        check("t2_busy_after_stop", bus_if.busy, 0);
        do_reset();

        // 1..9 then run dry
        push_n(1, 1, 9);
        pulse_start();
        wait_valid(k);
        check("t3_latency",  k, 11);
        check("t3_data",     bus_if.out_data,  11);
        check("t3_index",    bus_if.out_index, 0);
        check("t3_underrun", bus_if.underrun,  1);
        check("t3_cs_reset", bus_if.cs_reset,  1);
        check("t3_busy",     bus_if.busy,      0);
        step();
        check("t3_valid_after", bus_if.out_valid, 0);
        do_reset();

        // fill to DEPTH in IDLE, 17th held until the first pop frees a slot
        for (int i = 0; i <= 16; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = 8'(100 + i);
            check("t4_in_ready_fill", bus_if.in_ready, (i < 16) ? 1 : 0);
            step();
        end
        check("t4_in_ready_full", bus_if.in_ready, 0);
        pulse_start();
        check("t4_in_ready_prime", bus_if.in_ready, 0);
        step();
        check("t4_in_ready_first_pop", bus_if.in_ready, 0);
        check("t4_cs_x_first", bus_if.cs_x, 100);
        step();
        check("t4_in_ready_freed", bus_if.in_ready, 1);
        check("t4_cs_x_second", bus_if.cs_x, 101);
        step();
        bus_if.in_valid = 1'b0;
        for (int j = 2; j <= 16; j++) begin
            check("t4_cs_x_order", bus_if.cs_x, 100 + j);
            step();
        end
        check("t4_underrun_end", bus_if.underrun, 0);
        step();
        check("t4_underrun_set", bus_if.underrun, 1);
        do_reset();

        // 12 samples, four results, then underrun; restart clears it
        push_n(1, 1, 12);
        pulse_start();
        wait_valid(k);
        check("t5_latency", k, 11);
        for (int j = 0; j < 4; j++) begin
            check("t5_valid",    bus_if.out_valid, 1);
            check("t5_data",     bus_if.out_data,  exp5[j]);
            check("t5_index",    bus_if.out_index, j);
            check("t5_underrun", bus_if.underrun,  (j == 3) ? 1 : 0);
            step();
        end
        check("t5_valid_end", bus_if.out_valid, 0);
        check("t5_busy_end",  bus_if.busy,      0);
        push_n(20, 0, 9);
        check("t5_underrun_sticky", bus_if.underrun, 1);
        pulse_start();
        check("t5_underrun_cleared", bus_if.underrun, 0);
        wait_valid(k);
        check("t5_restart_latency", k, 11);
        check("t5_restart_data",    bus_if.out_data,  45);
        check("t5_restart_index",   bus_if.out_index, 0);
        do_reset();

        // stop after five pops: sixth pop happens in the stop cycle
        push_n(1, 1, 12);
        pulse_start();
        step();
        for (int j = 0; j < 5; j++) begin
            check("t6_cs_x",        bus_if.cs_x,     j + 1);
            check("t6_cs_reset_lo", bus_if.cs_reset, 0);
            step();
        end
        bus_if.stop = 1'b1;
        check("t6_cs_x_stop", bus_if.cs_x, 6);
        step();
        bus_if.stop = 1'b0;
        check("t6_cs_reset_hi", bus_if.cs_reset,  1);
        check("t6_busy",        bus_if.busy,      0);
        check("t6_out_valid",   bus_if.out_valid, 0);
        check("t6_underrun",    bus_if.underrun,  0);
        fill_count(n);
        check("t6_free_slots", n, 10);
        do_reset();

        // reset in the middle of STREAM
        push_n(1, 1, 12);
        pulse_start();
        wait_valid(k);
        check("t7_latency", k, 11);
        reset = 1'b1;
        step();
        check("t7_in_ready",  bus_if.in_ready,  1);
        check("t7_cs_reset",  bus_if.cs_reset,  1);
        check("t7_cs_x",      bus_if.cs_x,      0);
        check("t7_busy",      bus_if.busy,      0);
        check("t7_out_valid", bus_if.out_valid, 0);
        check("t7_out_data",  bus_if.out_data,  0);
        check("t7_out_index", bus_if.out_index, 0);
        check("t7_underrun",  bus_if.underrun,  0);
        reset = 1'b0;
        step();
        check("t7_out_valid_after", bus_if.out_valid, 0);
        fill_count(n);
        check("t7_fifo_empty", n, 16);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
